// File: rtl/freq_meter.sv
// freq_meter: measures the period of a slow square wave in clk_en samples.
// Ports: clk, rst (async, active-high), clk_en (sample strobe), sig_in
//   (async square wave) -> period (averaged result), valid (one-clk
//   pulse per result), locked (results are flowing), timeout (sticky).
module freq_meter #(
  parameter int W    = 16,
  parameter int AVG  = 2,
  parameter int FILT = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clk_en,
  input  logic         sig_in,
  output logic [W-1:0] period,
  output logic         valid,
  output logic         locked,
  output logic         timeout
);

  localparam int AW = W + AVG;
  localparam int NW = AVG + 1;
  localparam int RW = $clog2(FILT + 1);

  localparam logic [W-1:0]  CMAX  = {{(W-1){1'b1}}, 1'b0};
  localparam logic [NW-1:0] NLAST = NW'((1 << AVG) - 1);
  localparam logic [RW-1:0] RLAST = RW'(FILT - 1);

  typedef enum logic {
    IDLE,
    MEASURE
  } state_e;

  logic [1:0]    sync_q, sync_d;
  logic          lvl_q, lvl_d;
  logic [RW-1:0] run_q, run_d;
  state_e        state_q, state_d;
  logic [W-1:0]  cnt_q, cnt_d;
  logic [AW-1:0] acc_q, acc_d;
  logic [NW-1:0] nper_q, nper_d;
  logic [W-1:0]  period_q, period_d;
  logic          valid_q, valid_d;
  logic          locked_q, locked_d;
  logic          timeout_q, timeout_d;

  logic          smp;
  logic          edge_w;
  logic [W-1:0]  m;
  logic [AW-1:0] sum;

  // sync_q[0] is the first flop; sync_q[1] feeds the filter
  assign smp = sync_q[1];
  assign m   = cnt_q + W'(1);
  assign sum = acc_q + AW'(m);

  always_comb begin
    sync_d    = {sync_q[0], sig_in};
    lvl_d     = lvl_q;
    run_d     = run_q;
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    nper_d    = nper_q;
    period_d  = period_q;
    valid_d   = 1'b0;
    locked_d  = locked_q;
    timeout_d = timeout_q;
    edge_w    = 1'b0;

    if (clk_en) begin
      // run_q counts samples seen at the new level so far
      if (smp == lvl_q) begin
        run_d = '0;
      end else if (run_q == RLAST) begin
        lvl_d  = smp;
        run_d  = '0;
        edge_w = smp;
      end else begin
        run_d = run_q + RW'(1);
      end

      unique case (state_q)
        IDLE: begin
          if (edge_w) begin
            state_d = MEASURE;
            cnt_d   = '0;
            acc_d   = '0;
            nper_d  = '0;
          end
        end
        MEASURE: begin
          if (edge_w) begin
            cnt_d = '0;
            if (nper_q == NLAST) begin
              period_d  = sum[AW-1:AVG];
              valid_d   = 1'b1;
              locked_d  = 1'b1;
              timeout_d = 1'b0;
              acc_d     = '0;
              nper_d    = '0;
            end else begin
              acc_d  = sum;
              nper_d = nper_q + NW'(1);
            end
          end else if (cnt_q == CMAX) begin
            // next sample would make m = 2^W, unrepresentable
            state_d   = IDLE;
            timeout_d = 1'b1;
            locked_d  = 1'b0;
            cnt_d     = '0;
            acc_d     = '0;
            nper_d    = '0;
          end else begin
            cnt_d = cnt_q + W'(1);
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q    <= '0;
      lvl_q     <= 1'b0;
      run_q     <= '0;
      state_q   <= IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      nper_q    <= '0;
      period_q  <= '0;
      valid_q   <= 1'b0;
      locked_q  <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      sync_q    <= sync_d;
      lvl_q     <= lvl_d;
      run_q     <= run_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      nper_q    <= nper_d;
      period_q  <= period_d;
      valid_q   <= valid_d;
      locked_q  <= locked_d;
      timeout_q <= timeout_d;
    end
  end

  assign period  = period_q;
  assign valid   = valid_q;
  assign locked  = locked_q;
  assign timeout = timeout_q;

endmodule

// File: tb/tb_freq_meter.sv
// tb_freq_meter: directed scoreboard bench for freq_meter.
// Drives a W=16 and a W=8 instance; results checked on valid.
module tb_freq_meter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic en16, sig16, en8, sig8;
  logic [15:0] per16;
  logic [7:0]  per8;
  logic v16, lk16, to16;
  logic v8, lk8, to8;

  freq_meter #(.W(16), .AVG(2), .FILT(2)) u16 (
    .clk(clk), .rst(rst), .clk_en(en16), .sig_in(sig16),
    .period(per16), .valid(v16), .locked(lk16), .timeout(to16)
  );

  freq_meter #(.W(8), .AVG(2), .FILT(2)) u8 (
    .clk(clk), .rst(rst), .clk_en(en8), .sig_in(sig8),
    .period(per8), .valid(v8), .locked(lk8), .timeout(to8)
  );

  typedef struct {
    int per;
    bit lk;
    bit to;
    int gap;
  } exp_t;

  exp_t q16[$];
  exp_t q8[$];

  int checks = 0;
  int fails  = 0;
  int smp16 = 0;
  int smp8  = 0;
  int last16 = -1;
  int last8  = -1;

  always @(posedge clk) begin
    if (en16) smp16 <= smp16 + 1;
    if (en8)  smp8  <= smp8 + 1;
  end

  task automatic chk(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s got=%0d want=%0d", nm, got, exp);
    end
  endtask

  task automatic score(input bit is8, input int per, input bit lk,
                       input bit to, input int sc);
    exp_t e;
    int last;
    bit empty;
    string nm;
    nm = is8 ? "w8" : "w16";
    last = is8 ? last8 : last16;
    empty = is8 ? (q8.size() == 0) : (q16.size() == 0);
    checks++;
    if (empty) begin
      fails++;
      $display("FAIL %s unexpected valid period=%0d", nm, per);
    end else begin
      if (is8) e = q8.pop_front();
      else     e = q16.pop_front();
      if (per != e.per || lk != e.lk || to != e.to ||
          (e.gap != 0 && sc - last != e.gap)) begin
        fails++;
        $display("FAIL %s result got p=%0d lk=%0d to=%0d gap=%0d want p=%0d lk=%0d to=%0d gap=%0d",
                 nm, per, lk, to, sc - last, e.per, e.lk, e.to, e.gap);
      end
    end
    if (is8) last8 = sc;
    else     last16 = sc;
  endtask

  always @(negedge clk) begin
    if (v16) score(1'b0, int'(per16), lk16, to16, smp16);
    if (v8)  score(1'b1, int'(per8), lk8, to8, smp8);
  end

  // one sample every 3 clk; starts and ends on a falling edge
  task automatic smp(input bit is8, input bit v, input int n);
    repeat (n) begin
      if (is8) sig8 = v;
      else     sig16 = v;
      @(negedge clk);
      @(negedge clk);
      if (is8) en8 = 1'b1;
      else     en16 = 1'b1;
      @(negedge clk);
      en8  = 1'b0;
      en16 = 1'b0;
    end
  endtask

  task automatic per(input bit is8, input int h, input int l);
    smp(is8, 1'b1, h);
    smp(is8, 1'b0, l);
  endtask

  // clk_en high on consecutive clks (W=8 instance)
  task automatic burst(input bit v, input int n);
    repeat (n) begin
      sig8 = v;
      en8  = 1'b1;
      @(negedge clk);
    end
  endtask

  task automatic do_rst;
    @(negedge clk);
    rst   = 1'b1;
    en16  = 1'b0;
    en8   = 1'b0;
    sig16 = 1'b0;
    sig8  = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst   = 1'b1;
    en16  = 1'b0;
    en8   = 1'b0;
    sig16 = 1'b0;
    sig8  = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst per16", int'(per16), 0);
    chk("rst v16", int'(v16), 0);
    chk("rst lk16", int'(lk16), 0);
    chk("rst to16", int'(to16), 0);
    chk("rst per8", int'(per8), 0);
    chk("rst lk8", int'(lk8), 0);
    chk("rst to8", int'(to8), 0);
    rst = 1'b0;

    // 100-sample square wave: results at edges 5 and 9
    q16.push_back('{100, 1'b1, 1'b0, 0});
    q16.push_back('{100, 1'b1, 1'b0, 400});
    smp(1'b0, 1'b0, 5);
    repeat (9) per(1'b0, 50, 50);
    per(1'b0, 50, 50);
    per(1'b0, 50, 50);
    chk("pre-rst lk16", int'(lk16), 1);
    chk("pre-rst per16", int'(per16), 100);

    // reset mid-measurement, asynchronously
    #2 rst = 1'b1;
    sig16 = 1'b0;
    #1;
    chk("async rst per16", int'(per16), 0);
    chk("async rst v16", int'(v16), 0);
    chk("async rst lk16", int'(lk16), 0);
    chk("async rst to16", int'(to16), 0);
    @(negedge clk);
    rst = 1'b0;

    // fresh IDLE edge plus four periods
    q16.push_back('{30, 1'b1, 1'b0, 0});
    smp(1'b0, 1'b0, 5);
    repeat (3) per(1'b0, 15, 15);
    chk("no early result", int'(per16), 0);
    per(1'b0, 15, 15);
    smp(1'b0, 1'b1, 2);

    // 10,11,10,11 -> 42>>2 = 10
    do_rst();
    q16.push_back('{10, 1'b1, 1'b0, 0});
    smp(1'b0, 1'b0, 5);
    per(1'b0, 5, 5);
    per(1'b0, 5, 6);
    per(1'b0, 5, 5);
    per(1'b0, 5, 6);
    smp(1'b0, 1'b1, 2);

    // single-sample glitches in both phases, period 40
    do_rst();
    q16.push_back('{40, 1'b1, 1'b0, 0});
    smp(1'b0, 1'b0, 5);
    repeat (4) begin
      smp(1'b0, 1'b1, 10);
      smp(1'b0, 1'b0, 1);
      smp(1'b0, 1'b1, 9);
      smp(1'b0, 1'b0, 10);
      smp(1'b0, 1'b1, 1);
      smp(1'b0, 1'b0, 9);
    end
    smp(1'b0, 1'b1, 2);

    // W=8: lock at 16, then stuck high -> timeout
    do_rst();
    q8.push_back('{16, 1'b1, 1'b0, 0});
    smp(1'b1, 1'b0, 5);
    repeat (4) per(1'b1, 8, 8);
    smp(1'b1, 1'b1, 2);
    smp(1'b1, 1'b1, 254);
    chk("w8 to before 254", int'(to8), 0);
    chk("w8 lk before 254", int'(lk8), 1);
    smp(1'b1, 1'b1, 1);
    chk("w8 timeout", int'(to8), 1);
    chk("w8 lk after to", int'(lk8), 0);
    chk("w8 period held", int'(per8), 16);
    smp(1'b1, 1'b1, 45);
    chk("w8 to sticky", int'(to8), 1);

    // re-acquire at 20
    q8.push_back('{20, 1'b1, 1'b0, 0});
    smp(1'b1, 1'b0, 5);
    repeat (4) per(1'b1, 10, 10);
    chk("w8 to until valid", int'(to8), 1);
    smp(1'b1, 1'b1, 2);
    @(negedge clk);
    chk("w8 to cleared", int'(to8), 0);

    // back-to-back clk_en, edge at cnt=254 -> m=255
    do_rst();
    q8.push_back('{255, 1'b1, 1'b0, 0});
    burst(1'b0, 5);
    repeat (4) begin
      burst(1'b1, 100);
      burst(1'b0, 155);
    end
    burst(1'b1, 6);
    en8 = 1'b0;
    repeat (3) @(negedge clk);
    chk("w8 max to", int'(to8), 0);
    chk("w8 max lk", int'(lk8), 1);

    repeat (5) @(negedge clk);
    chk("q16 drained", q16.size(), 0);
    chk("q8 drained", q8.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule

// File: doc/freq_meter.md
FREQ_METER -- requirements
Module: freq_meter

Interface
REQ-001 Parameter W, default 16: width of the period counter and of the period output.
REQ-002 Parameter AVG, default 2: log2 of the number of periods averaged per result.
REQ-003 Parameter FILT, default 2: number of consecutive equal samples needed to accept a level change.
REQ-004 clk  input  1  system clock; all state changes on its rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 clk_en  input  1  sample strobe; one clk wide, at the sample rate.
REQ-007 sig_in  input  1  square-wave input; asynchronous to clk (e.g. sign bit of the filter output).
REQ-008 period  output  W  last averaged period, in samples.
REQ-009 valid  output  1  one-clk pulse when period is updated.
REQ-010 locked  output  1  high while consecutive results are being produced.
REQ-011 timeout  output  1  sticky flag: no edge was seen within 2^W-1 samples.

Function
REQ-012 sig_in SHALL pass through a 2-flop synchronizer clocked every clk, regardless of clk_en.
REQ-013 Glitch filter, updated only on clk_en cycles:
- filtered level changes only after FILT consecutive samples at the new synchronized level;
- any sample at the old level resets the run count.
REQ-014 An edge event SHALL be the sample on which the filtered level goes 0->1; no other sample is an edge.
REQ-015 States: IDLE (after reset) and MEASURE; the FSM, cnt and acc advance only on clk_en cycles.
REQ-016 IDLE behaviour:
- edge -> MEASURE with cnt=0, acc=0, nper=0;
- no timeout is generated in IDLE.
REQ-017 MEASURE, no edge: cnt increments by 1.
REQ-018 MEASURE, edge:
- m = cnt+1;
- acc += m; nper += 1; cnt = 0.
REQ-019 When nper reaches 2^AVG:
- period <= (acc+m) >> AVG, truncated;
- valid pulses for one clk in the cycle after that clk_en cycle;
- locked <= 1; acc and nper cleared; state stays MEASURE.
REQ-020 acc SHALL be W+AVG bits wide and SHALL never overflow.
REQ-021 Timeout, MEASURE with cnt == 2^W-2 and no edge:
- next state IDLE; timeout <= 1; locked <= 0;
- cnt, acc and nper cleared; period held.
REQ-022 An edge at cnt == 2^W-2 SHALL be a normal measurement with m = 2^W-1 and no timeout.
REQ-023 timeout SHALL clear on the same clk that valid asserts.
REQ-024 clk_en low: cnt, acc, nper, FSM and filter hold; valid is 0.
REQ-025 clk_en asserted on consecutive clk cycles SHALL still behave per sample.

Reset
REQ-026 rst asserted, at any time including mid-measurement, SHALL immediately set:
- period=0, valid=0, locked=0, timeout=0;
- state IDLE; cnt, acc, nper cleared;
- synchronizer and filtered level to 0, run count 0.
REQ-027 After rst deasserts, the first result SHALL require a fresh IDLE edge plus 2^AVG full periods.

Verification (W=16, AVG=2, FILT=2 unless stated)
REQ-028 Ideal square wave, 100 samples per period (50 high/50 low), clk_en every 1042 clk.
- Required: first valid after the 5th rising edge, period=100, locked=1.
- Required: valid repeats every 400 samples.
REQ-029 Periods 10,11,10,11 samples -> period=10 (42>>2, truncated).
REQ-030 Single-sample low glitch inside a high phase, and single-sample high glitch inside a low phase.
- Required: no edge event; period unchanged vs. the glitch-free run.
REQ-031 W=8, sig_in held high for 300 samples after entering MEASURE.
- Required: timeout=1 and locked=0 at cnt=254; no valid.
- Then 4 periods of 20 samples (after re-acquire) -> period=20, valid=1, timeout=0.
REQ-032 Two consecutive clk_en cycles with the edge at cnt=65534 -> m=65535, no timeout.
REQ-033 rst pulsed mid-measurement (after 2 periods).
- Required: all outputs 0 immediately.
- Required: next valid only after a new IDLE edge plus 4 periods.
